// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_control_fsm                                       |
// | Description : Multi-cycle instruction sequencer (IFETCH/DECODE/EXEC/MEM/WB)|
// |               with memory and MUL/DIV handshakes, HALT and watchdog.       |
// |               Optional macro ILLEGAL_TRAP_EN traps undefined op/func.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multicycle_control_fsm #(
    parameter int OP_W     = 4,
    parameter int FN_W     = 4,
    parameter int WAIT_MAX = 63
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] func,
    input  logic            mem_ack,
    input  logic            md_done,
    output logic            mem_req,
    output logic            ifetch,
    output logic            ir_we,
    output logic            pc_we,
    output logic            md_start,
    output logic            rf_we,
    output logic            offset,
    output logic            imm,
    output logic            down,
    output logic            mbyte,
    output logic            mv1src,
    output logic [1:0]      wdst,
    output logic [1:0]      memw,
    output logic            halt,
    output logic            err,
    output logic            illegal
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MDWAIT = 4'd4,
        S_MEM    = 4'd5,
        S_WB     = 4'd6,
        S_WB2    = 4'd7,
        S_HALT   = 4'd8,
        S_TRAP   = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        C_ALU   = 3'd0,
        C_MD    = 3'd1,
        C_SWAP  = 3'd2,
        C_LOAD  = 3'd3,
        C_STORE = 3'd4,
        C_HALT  = 3'd5,
        C_UNDEF = 3'd6
    } cls_t;

    state_t           state;
    state_t           state_d;
    cls_t             cls;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;
    logic             waiting;

    logic [3:0] op4;
    logic [3:0] fn4;
    logic       op_hi_ok;
    logic       fn_hi_ok;

    cls_t       dec_cls;
    logic       dec_offset;
    logic       dec_imm;
    logic       dec_down;
    logic       dec_mbyte;
    logic       dec_mv1src;
    logic [1:0] dec_wdst;
    logic [1:0] dec_memw;

    assign op4      = opcode[3:0];
    assign fn4      = func[3:0];
    assign op_hi_ok = (opcode >> 4) == '0;
    assign fn_hi_ok = (func >> 4) == '0;

    always_comb begin
        dec_cls    = C_UNDEF;
        dec_offset = 1'b0;
        dec_imm    = 1'b0;
        dec_down   = 1'b0;
        dec_mbyte  = 1'b0;
        dec_mv1src = 1'b1;
        dec_wdst   = 2'b00;
        dec_memw   = 2'b00;
        if (op_hi_ok) begin
            case (op4)
                4'hF: begin
                    if (fn_hi_ok) begin
                        case (fn4)
                            4'h0, 4'h1, 4'h2, 4'h3, 4'h6: dec_cls = C_ALU;
                            4'h4, 4'h5: begin
                                dec_cls  = C_MD;
                                dec_wdst = 2'b10;
                            end
                            4'h7: begin
                                dec_cls    = C_ALU;
                                dec_mv1src = 1'b0;
                            end
                            4'h8: begin
                                dec_cls    = C_SWAP;
                                dec_mv1src = 1'b0;
                                dec_wdst   = 2'b01;
                            end
                            4'hF:    dec_cls = C_HALT;
                            default: dec_cls = C_UNDEF;
                        endcase
                    end
                end
                4'h8, 4'h9: begin
                    dec_cls = C_ALU;
                    dec_imm = 1'b1;
                end
                4'hA: begin
                    dec_cls    = C_LOAD;
                    dec_offset = 1'b1;
                    dec_mbyte  = 1'b1;
                    dec_down   = 1'b1;
                end
                4'hB: begin
                    dec_cls    = C_STORE;
                    dec_offset = 1'b1;
                    dec_memw   = 2'b01;
                end
                4'hC: begin
                    dec_cls    = C_LOAD;
                    dec_offset = 1'b1;
                    dec_down   = 1'b1;
                end
                4'hD: begin
                    dec_cls    = C_STORE;
                    dec_offset = 1'b1;
                    dec_memw   = 2'b10;
                end
                default: dec_cls = C_UNDEF;
            endcase
        end
    end

    assign waiting = (state == S_FETCH) || (state == S_MEM) || (state == S_MDWAIT);

    // A handshake arriving on the last allowed cycle takes priority over the timeout.
    always_comb begin
        state_d = state;
        timeout = 1'b0;
        case (state)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ack) begin
                    state_d = S_DECODE;
                end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                case (dec_cls)
                    C_HALT:  state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
                    C_UNDEF: state_d = S_TRAP;
`else
                    C_UNDEF: state_d = S_FETCH;
`endif
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls)
                    C_MD:            state_d = S_MDWAIT;
                    C_LOAD, C_STORE: state_d = S_MEM;
                    default:         state_d = S_WB;
                endcase
            end
            S_MDWAIT: begin
                if (md_done) begin
                    state_d = S_WB;
                end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d = (cls == C_LOAD) ? S_WB : S_FETCH;
                end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
                    timeout = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_WB:     state_d = (cls == C_SWAP) ? S_WB2 : S_FETCH;
            S_WB2:    state_d = S_FETCH;
            S_HALT:   if (run) state_d = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:   if (run) state_d = S_FETCH;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // IR/PC load must land on the edge that completes the fetch, so these follow mem_ack directly.
    assign ir_we = (state == S_FETCH) && mem_ack;
    assign pc_we = (state == S_FETCH) && mem_ack;

`ifndef ILLEGAL_TRAP_EN
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cls      <= C_ALU;
            wait_cnt <= '0;
            mem_req  <= 1'b0;
            ifetch   <= 1'b0;
            md_start <= 1'b0;
            rf_we    <= 1'b0;
            offset   <= 1'b0;
            imm      <= 1'b0;
            down     <= 1'b0;
            mbyte    <= 1'b0;
            mv1src   <= 1'b1;
            wdst     <= 2'b00;
            memw     <= 2'b00;
            halt     <= 1'b0;
            err      <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal  <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            mem_req  <= (state_d == S_FETCH) || (state_d == S_MEM);
            ifetch   <= (state_d == S_FETCH);
            md_start <= (state_d == S_EXEC) && (dec_cls == C_MD);
            rf_we    <= (state_d == S_WB) || (state_d == S_WB2);
            halt     <= (state_d == S_HALT) || (state_d == S_TRAP);
`ifdef ILLEGAL_TRAP_EN
            illegal  <= (state_d == S_TRAP);
`endif
            if (timeout) begin
                err <= 1'b1;
            end
            if (state_d != state) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == S_DECODE) begin
                cls <= dec_cls;
                if (dec_cls != C_UNDEF) begin
                    offset <= dec_offset;
                    imm    <= dec_imm;
                    down   <= dec_down;
                    mbyte  <= dec_mbyte;
                    mv1src <= dec_mv1src;
                    wdst   <= dec_wdst;
                    memw   <= dec_memw;
                end
            end
            // Second SWAP write targets destination 00.
            if ((state == S_WB) && (state_d == S_WB2)) begin
                wdst <= 2'b00;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multicycle_control_fsm                                    |
// | Description : Self-checking bench for multicycle_control_fsm with an       |
// |               instruction-level timing model and random stimulus.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n, run, mem_ack, md_done;
    logic [3:0] opcode, func;
    logic       mem_req, ifetch, ir_we, pc_we, md_start, rf_we;
    logic       offset, imm, down, mbyte, mv1src, halt, err, illegal;
    logic [1:0] wdst, memw;

    int total = 0;
    int bad   = 0;

    localparam int K_ALU = 0, K_MD = 1, K_SWAP = 2, K_LOAD = 3, K_STORE = 4, K_HALT = 5, K_UNDEF = 6;

    int         o_len, o_freq, o_dreq, o_rf, o_mds, o_irw, o_pcw;
    logic [1:0] o_wd [4];
    logic [1:0] o_memw;
    logic       o_consec, o_halted, o_started;

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .func(func),
        .mem_ack(mem_ack), .md_done(md_done), .mem_req(mem_req), .ifetch(ifetch),
        .ir_we(ir_we), .pc_we(pc_we), .md_start(md_start), .rf_we(rf_we),
        .offset(offset), .imm(imm), .down(down), .mbyte(mbyte), .mv1src(mv1src),
        .wdst(wdst), .memw(memw), .halt(halt), .err(err), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic int classify(input logic [3:0] op, input logic [3:0] fn);
        if (op == 4'hF) begin
            if (fn inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7}) return K_ALU;
            if (fn inside {4'h4, 4'h5}) return K_MD;
            if (fn == 4'h8) return K_SWAP;
            if (fn == 4'hF) return K_HALT;
            return K_UNDEF;
        end
        if (op inside {4'h8, 4'h9}) return K_ALU;
        if (op inside {4'hA, 4'hC}) return K_LOAD;
        if (op inside {4'hB, 4'hD}) return K_STORE;
        return K_UNDEF;
    endfunction

    // Cycles from the first fetch cycle of one instruction to the first fetch cycle of the next.
    function automatic int exp_len(input int k, input int df, input int dm, input int lat);
        case (k)
            K_ALU:   return df + 4;
            K_MD:    return df + lat + 4;
            K_SWAP:  return df + 5;
            K_LOAD:  return df + dm + 5;
            K_STORE: return df + dm + 4;
            default: return df + 2;
        endcase
    endfunction

    function automatic int exp_rf(input int k);
        if (k == K_SWAP) return 2;
        if (k == K_ALU || k == K_MD || k == K_LOAD) return 1;
        return 0;
    endfunction

    // {offset, imm, down, mbyte, mv1src, wdst[1:0], memw[1:0]}
    function automatic logic [8:0] exp_sel(input logic [3:0] op, input logic [3:0] fn);
        logic [8:0] s;
        s[8]   = (op >= 4'hA) && (op <= 4'hD);
        s[7]   = (op == 4'h8) || (op == 4'h9);
        s[6]   = (op == 4'hA) || (op == 4'hC);
        s[5]   = (op == 4'hA);
        s[4]   = !((op == 4'hF) && (fn == 4'h7 || fn == 4'h8));
        s[3:2] = (op == 4'hF && (fn == 4'h4 || fn == 4'h5)) ? 2'b10 :
                 (op == 4'hF && fn == 4'h8) ? 2'b01 : 2'b00;
        s[1:0] = (op == 4'hB) ? 2'b01 : (op == 4'hD) ? 2'b10 : 2'b00;
        return s;
    endfunction

    // Enter at a negedge in the first fetch cycle; leave at the next fetch cycle or on halt.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] fn, input int df, input int dm, input int lat);
        int   cyc;
        int   md_t;
        logic fetched, fin, last_rf;
        opcode = op; func = fn;
        cyc = 0; md_t = -1; fetched = 0; fin = 0; last_rf = 0;
        o_freq = 0; o_dreq = 0; o_rf = 0; o_mds = 0; o_irw = 0; o_pcw = 0;
        o_consec = 1; o_halted = 0; o_memw = 2'b11;
        for (int i = 0; i < 4; i++) o_wd[i] = 2'b11;
        while (!fin) begin
            if (mem_req && ifetch) o_freq++;
            if (mem_req && !ifetch) begin o_dreq++; o_memw = memw; end
            if (md_start) begin o_mds++; md_t = cyc; end
            if (rf_we) begin
                if (o_rf > 0 && !last_rf) o_consec = 0;
                if (o_rf < 4) o_wd[o_rf] = wdst;
                o_rf++;
            end
            last_rf = rf_we;
            mem_ack = (mem_req && ifetch && o_freq == df + 1) || (mem_req && !ifetch && o_dreq == dm + 1);
            if (mem_req && ifetch && mem_ack) fetched = 1;
            md_done = md_start || (md_t >= 0 && (cyc == md_t + lat || cyc == md_t + lat + 1));
            #1;
            if (ir_we) o_irw++;
            if (pc_we) o_pcw++;
            @(negedge clk);
            cyc++;
            if (halt) begin o_halted = 1; fin = 1; end
            else if (fetched && mem_req && ifetch) fin = 1;
            else if (cyc >= 400) fin = 1;
        end
        o_len = cyc;
        mem_ack = 0; md_done = 0;
    endtask

    task automatic restart();
        int n = 0;
        run = 1'b1;
        @(negedge clk);
        while (!(mem_req && ifetch) && n < 10) begin @(negedge clk); n++; end
        run = 1'b0;
        o_started = mem_req && ifetch;
    endtask

    task automatic test_reset();
        rst_n = 0; run = 0; mem_ack = 0; md_done = 0; opcode = 0; func = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({mem_req, ifetch, ir_we, pc_we, md_start, rf_we, offset, imm, down, mbyte, mv1src,
             wdst, memw, halt, err, illegal} !== 18'h00080) begin
            bad++; $display("FAIL reset_outputs got=%h exp=%h", {mem_req, ifetch, ir_we, pc_we, md_start,
                rf_we, offset, imm, down, mbyte, mv1src, wdst, memw, halt, err, illegal}, 18'h00080);
        end
        rst_n = 1;
        repeat (3) @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_no_req got=%b exp=0", mem_req); end
        restart();
        total++; if (o_started !== 1'b1) begin bad++; $display("FAIL reset_start got=%b exp=1", o_started); end
    endtask

    task automatic test_add();
        run_instr(4'hF, 4'h0, 1, 0, 0);
        total++; if (o_len != 5) begin bad++; $display("FAIL add_len got=%0d exp=5", o_len); end
        total++; if (o_rf != 1) begin bad++; $display("FAIL add_rf got=%0d exp=1", o_rf); end
        total++; if (o_irw != 1 || o_pcw != 1) begin bad++; $display("FAIL add_irpc got=%0d/%0d exp=1/1", o_irw, o_pcw); end
    endtask

    task automatic test_lb();
        int df = $urandom_range(0, 3);
        run_instr(4'hA, 4'h0, df, 3, 0);
        total++; if (o_len != df + 8) begin bad++; $display("FAIL lb_len got=%0d exp=%0d", o_len, df + 8); end
        total++; if (o_dreq != 4) begin bad++; $display("FAIL lb_dreq got=%0d exp=4", o_dreq); end
        total++; if ({offset, mbyte, down} !== 3'b111) begin bad++; $display("FAIL lb_sel got=%b exp=111", {offset, mbyte, down}); end
        total++; if (o_rf != 1) begin bad++; $display("FAIL lb_rf got=%0d exp=1", o_rf); end
    endtask

    task automatic test_sw();
        run_instr(4'hD, 4'h0, 1, 2, 0);
        total++; if (o_memw !== 2'b10) begin bad++; $display("FAIL sw_memw got=%b exp=10", o_memw); end
        total++; if (o_rf != 0) begin bad++; $display("FAIL sw_rf got=%0d exp=0", o_rf); end
        total++; if (o_len != 7) begin bad++; $display("FAIL sw_len got=%0d exp=7", o_len); end
    endtask

    task automatic test_mul();
        run_instr(4'hF, 4'h4, 1, 0, 10);
        total++; if (o_mds != 1) begin bad++; $display("FAIL mul_start got=%0d exp=1", o_mds); end
        total++; if (o_rf != 1 || o_wd[0] !== 2'b10) begin bad++; $display("FAIL mul_wb got=%0d/%b exp=1/10", o_rf, o_wd[0]); end
        total++; if (o_len != 15) begin bad++; $display("FAIL mul_len got=%0d exp=15", o_len); end
    endtask

    task automatic test_swap();
        run_instr(4'hF, 4'h8, 0, 0, 0);
        total++; if (o_rf != 2 || o_consec !== 1'b1) begin bad++; $display("FAIL swap_rf got=%0d/%b exp=2/1", o_rf, o_consec); end
        total++; if ({o_wd[0], o_wd[1]} !== 4'b0100) begin bad++; $display("FAIL swap_wdst got=%b exp=0100", {o_wd[0], o_wd[1]}); end
        total++; if (mv1src !== 1'b0) begin bad++; $display("FAIL swap_mv1src got=%b exp=0", mv1src); end
        total++; if (o_len != 5) begin bad++; $display("FAIL swap_len got=%0d exp=5", o_len); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [3:0] op, fn;
            logic [8:0] es;
            int df, dm, lat, k;
            if ($urandom_range(0, 1) == 1) begin op = 4'hF; fn = 4'($urandom_range(0, 8)); end
            else begin op = 4'(8 + $urandom_range(0, 5)); fn = 4'($urandom_range(0, 15)); end
            df = $urandom_range(0, 4); dm = $urandom_range(0, 4); lat = $urandom_range(1, 6);
            k = classify(op, fn); es = exp_sel(op, fn);
            run_instr(op, fn, df, dm, lat);
            total++; if (o_len != exp_len(k, df, dm, lat)) begin bad++; $display("FAIL rnd_len op=%h fn=%h got=%0d exp=%0d", op, fn, o_len, exp_len(k, df, dm, lat)); end
            total++; if (o_rf != exp_rf(k)) begin bad++; $display("FAIL rnd_rf op=%h fn=%h got=%0d exp=%0d", op, fn, o_rf, exp_rf(k)); end
            total++; if (o_mds != ((k == K_MD) ? 1 : 0)) begin bad++; $display("FAIL rnd_mds op=%h fn=%h got=%0d", op, fn, o_mds); end
            total++; if (o_dreq != ((k == K_LOAD || k == K_STORE) ? dm + 1 : 0)) begin bad++; $display("FAIL rnd_dreq op=%h got=%0d dm=%0d", op, o_dreq, dm); end
            total++; if ({offset, imm, down, mbyte, mv1src, memw} !== {es[8:4], es[1:0]}) begin bad++; $display("FAIL rnd_sel op=%h fn=%h got=%b exp=%b", op, fn, {offset, imm, down, mbyte, mv1src, memw}, {es[8:4], es[1:0]}); end
            if (o_rf > 0) begin
                total++; if (o_wd[0] !== es[3:2]) begin bad++; $display("FAIL rnd_wdst op=%h fn=%h got=%b exp=%b", op, fn, o_wd[0], es[3:2]); end
            end
            if (o_dreq > 0) begin
                total++; if (o_memw !== es[1:0]) begin bad++; $display("FAIL rnd_memw op=%h got=%b exp=%b", op, o_memw, es[1:0]); end
            end
        end
    endtask

    task automatic test_undefined();
        run_instr(4'h0, 4'h0, 1, 0, 0);
        total++; if (o_rf != 0) begin bad++; $display("FAIL undef_rf got=%0d exp=0", o_rf); end
        total++; if (o_len != 3) begin bad++; $display("FAIL undef_len got=%0d exp=3", o_len); end
`ifdef ILLEGAL_TRAP_EN
        total++; if ({illegal, halt} !== 2'b11) begin bad++; $display("FAIL trap_flags got=%b exp=11", {illegal, halt}); end
        restart();
        total++; if ({o_started, illegal, halt} !== 3'b100) begin bad++; $display("FAIL trap_resume got=%b exp=100", {o_started, illegal, halt}); end
`else
        total++; if ({o_halted, illegal} !== 2'b00) begin bad++; $display("FAIL nop_flags got=%b exp=00", {o_halted, illegal}); end
`endif
    endtask

    task automatic test_halt();
        run_instr(4'hF, 4'hF, 0, 0, 0);
        total++; if (o_halted !== 1'b1 || o_len != 2) begin bad++; $display("FAIL halt_enter got=%b/%0d exp=1/2", o_halted, o_len); end
        repeat (4) @(negedge clk);
        total++; if ({halt, mem_req, rf_we} !== 3'b100) begin bad++; $display("FAIL halt_hold got=%b exp=100", {halt, mem_req, rf_we}); end
        restart();
        total++; if ({o_started, halt} !== 2'b10) begin bad++; $display("FAIL halt_resume got=%b exp=10", {o_started, halt}); end
    endtask

    task automatic test_watchdog();
        run_instr(4'hF, 4'h0, 62, 0, 0);
        total++; if (o_len != 66 || err !== 1'b0) begin bad++; $display("FAIL wd_edge got=%0d/%b exp=66/0", o_len, err); end
        run_instr(4'hF, 4'h0, 200, 0, 0);
        total++; if (o_freq != 63) begin bad++; $display("FAIL wd_reqcyc got=%0d exp=63", o_freq); end
        total++; if ({err, halt, mem_req} !== 3'b110) begin bad++; $display("FAIL wd_flags got=%b exp=110", {err, halt, mem_req}); end
        restart();
        run_instr(4'hF, 4'h1, 1, 0, 0);
        total++; if (o_started !== 1'b1 || o_len != 5 || err !== 1'b1) begin bad++; $display("FAIL wd_resume got=%b/%0d/%b exp=1/5/1", o_started, o_len, err); end
    endtask

    task automatic test_mid_reset();
        run_instr(4'hF, 4'h7, 0, 0, 0);
        opcode = 4'hA;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        total++;
        if ({mem_req, ifetch, ir_we, pc_we, md_start, rf_we, offset, imm, down, mbyte, mv1src,
             wdst, memw, halt, err, illegal} !== 18'h00080) begin
            bad++; $display("FAIL midreset_outputs got=%h exp=%h", {mem_req, ifetch, ir_we, pc_we, md_start,
                rf_we, offset, imm, down, mbyte, mv1src, wdst, memw, halt, err, illegal}, 18'h00080);
        end
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL midreset_idle got=%b exp=0", mem_req); end
        restart();
        run_instr(4'hF, 4'h2, 1, 0, 0);
        total++; if (o_started !== 1'b1 || o_len != 5) begin bad++; $display("FAIL midreset_resume got=%b/%0d exp=1/5", o_started, o_len); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lb();
        test_sw();
        test_mul();
        test_swap();
        test_random();
        test_undefined();
        test_halt();
        test_watchdog();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
